// File: rtl/sfq_seq_pkg.sv
// Shared types and helpers for the SFQ DFFT pulse sequencer.
// Holds the FSM state encoding, default timing constants and a saturating increment.
package sfq_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CLKP,
    WINDOW,
    RESP,
    HOLD
  } state_t;

  localparam int SETUP_CYC_DEF = 3;
  localparam int WIN_CYC_DEF   = 4;
  localparam int HOLD_CYC_DEF  = 2;

  // Increment v, sticking at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sfq_toggle_detect.sv
// Converts a toggle-encoded SFQ wire into a one-cycle pulse per level transition.
// The reference level reloads every cycle, so reset leaves no false edge behind.
module sfq_toggle_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_lvl,
  output logic o_pulse
);

  logic r_prev;

  always_ff @(posedge clk) begin
    r_prev <= i_lvl;
  end

  assign o_pulse = (i_lvl ^ r_prev) & ~rst;

endmodule

// File: rtl/sfq_dfft_pulse_sequencer.sv
// Drives one DFFT-style SFQ cell through a set / clk / capture cycle per request,
// returning the captured bit and tracking mismatches and out-of-window pulses.
module sfq_dfft_pulse_sequencer
  import sfq_seq_pkg::*;
#(
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int WIN_CYC   = WIN_CYC_DEF,
  parameter int HOLD_CYC  = HOLD_CYC_DEF,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_data,
  output logic             req_ready,
  output logic             sfq_set_o,
  output logic             sfq_clk_o,
  input  logic             sfq_out_i,
  output logic             rsp_valid,
  output logic             rsp_data,
  output logic             rsp_mismatch,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] spurious_cnt,
  output logic             err_spurious
);

  state_t           r_state, w_state_nxt;
  logic [15:0]      r_cnt, w_cnt_nxt;
  logic             r_bit, r_cap, r_set, r_clk, r_err;
  logic [CNT_W-1:0] r_mis_cnt, r_spur_cnt;
  logic             w_pulse, w_accept, w_tog_set, w_tog_clk;
  logic             w_capture, w_spur, w_mis;

  sfq_toggle_detect u_out_det (
    .clk     (clk),
    .rst     (rst),
    .i_lvl   (sfq_out_i),
    .o_pulse (w_pulse)
  );

  assign w_accept  = (r_state == IDLE) && req_valid;
  assign w_mis     = r_cap ^ r_bit;
  // Only the first pulse inside the window counts; every other pulse is spurious.
  assign w_capture = w_pulse && (r_state == WINDOW) && !r_cap;
  assign w_spur    = w_pulse && !w_capture;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tog_set   = 1'b0;
    w_tog_clk   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_state_nxt = SETUP;
          w_cnt_nxt   = '0;
          w_tog_set   = req_data;
        end
      end
      SETUP: begin
        if (r_cnt == 16'(SETUP_CYC - 1)) begin
          w_state_nxt = CLKP;
          w_cnt_nxt   = '0;
          w_tog_clk   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      CLKP: begin
        w_state_nxt = WINDOW;
        w_cnt_nxt   = '0;
      end
      WINDOW: begin
        if (r_cnt == 16'(WIN_CYC - 1)) begin
          w_state_nxt = RESP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      RESP: begin
        w_state_nxt = (HOLD_CYC == 0) ? IDLE : HOLD;
        w_cnt_nxt   = '0;
      end
      HOLD: begin
        if (r_cnt == 16'(HOLD_CYC - 1)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit      <= 1'b0;
      r_cap      <= 1'b0;
      r_set      <= 1'b0;
      r_clk      <= 1'b0;
      r_mis_cnt  <= '0;
      r_spur_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_set   <= r_set ^ w_tog_set;
      r_clk   <= r_clk ^ w_tog_clk;
      if (w_accept) begin
        r_bit <= req_data;
        r_cap <= 1'b0;
      end else if (w_capture) begin
        r_cap <= 1'b1;
      end
      if (w_spur) begin
        r_spur_cnt <= CNT_W'(sat_inc(32'(r_spur_cnt), CNT_W));
        r_err      <= 1'b1;
      end
      if ((r_state == RESP) && w_mis) begin
        r_mis_cnt <= CNT_W'(sat_inc(32'(r_mis_cnt), CNT_W));
      end
    end
  end

  assign req_ready    = (r_state == IDLE) && !rst;
  assign sfq_set_o    = r_set;
  assign sfq_clk_o    = r_clk;
  assign rsp_valid    = (r_state == RESP);
  assign rsp_data     = rsp_valid && r_cap;
  assign rsp_mismatch = rsp_valid && w_mis;
  assign mismatch_cnt = r_mis_cnt;
  assign spurious_cnt = r_spur_cnt;
  assign err_spurious = r_err;

endmodule
